// File: rtl/time_set_ctrl.sv
// time_set_ctrl: mode/sequencing controller for the sec/min/hr BCD counter chain.
// In RUN, ticks and carries become registered one-cycle step pulses. In the
// SET modes, ripple is gated and the selected field is stepped from key_inc,
// with hold-to-repeat on hours and minutes, plus a blink phase for the display.
// Optional feature macro: AUTO_EXIT_EN (return to RUN after TIMEOUT_TICKS
// ticks with no key activity while setting).
module time_set_ctrl #(
  parameter logic [15:0] HOLD_CYCLES   = 16'd500,
  parameter logic [15:0] REPEAT_CYCLES = 16'd100,
  parameter logic [15:0] BLINK_DIV     = 16'd250,
  parameter logic [5:0]  TIMEOUT_TICKS = 6'd30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       sec_carry,
  input  logic       min_carry,
  output logic       sec_step,
  output logic       min_step,
  output logic       hr_step,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_t;

  mode_t       mode_reg, mode_next;
  logic        mode_q_reg, inc_q_reg;
  logic        mode_rise, inc_rise;
  logic        sec_step_reg, sec_step_next;
  logic        min_step_reg, min_step_next;
  logic        hr_step_reg, hr_step_next;
  logic        sec_clr_reg, sec_clr_next;
  logic        blink_reg, blink_next;
  logic [15:0] blink_cnt_reg, blink_cnt_next;
  logic [15:0] hold_cnt_reg, hold_cnt_next;
  logic [15:0] rep_cnt_reg, rep_cnt_next;
  logic        rep_phase_reg, rep_phase_next;
  logic        timeout_hit;
  logic        mode_change;
  logic        step_req;

  assign mode_rise = key_mode & ~mode_q_reg;
  assign inc_rise  = key_inc & ~inc_q_reg;

`ifdef AUTO_EXIT_EN
  logic [5:0] to_cnt_reg, to_cnt_next;

  assign timeout_hit = (mode_reg != MODE_RUN) && (to_cnt_reg == TIMEOUT_TICKS);

  // Idle-tick counter: saturates at the timeout, restarts on any key rise or mode change.
  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (mode_reg == MODE_RUN || mode_rise || timeout_hit || inc_rise) begin
      to_cnt_next = 6'd0;
    end else if (tick && to_cnt_reg != TIMEOUT_TICKS) begin
      to_cnt_next = to_cnt_reg + 6'd1;
    end
  end

  // Idle-tick counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_reg <= 6'd0;
    end else begin
      to_cnt_reg <= to_cnt_next;
    end
  end
`else
  logic [5:0] unused_timeout;
  assign unused_timeout = TIMEOUT_TICKS;
  assign timeout_hit    = 1'b0;
`endif

  assign mode_change = mode_rise | timeout_hit;

  // Next mode, step/clear pulses, auto-repeat and blink sequencing.
  always_comb begin
    mode_next      = mode_reg;
    sec_step_next  = 1'b0;
    min_step_next  = 1'b0;
    hr_step_next   = 1'b0;
    sec_clr_next   = 1'b0;
    blink_next     = blink_reg;
    blink_cnt_next = blink_cnt_reg;
    hold_cnt_next  = hold_cnt_reg;
    rep_cnt_next   = rep_cnt_reg;
    rep_phase_next = rep_phase_reg;
    step_req       = 1'b0;

    if (mode_rise) begin
      case (mode_reg)
        MODE_RUN:     mode_next = MODE_SET_HR;
        MODE_SET_HR:  mode_next = MODE_SET_MIN;
        MODE_SET_MIN: mode_next = MODE_SET_SEC;
        default:      mode_next = MODE_RUN;
      endcase
    end else if (timeout_hit) begin
      mode_next = MODE_RUN;
    end

    if (mode_reg == MODE_RUN) begin
      // Plain ripple: the counters see the inputs one cycle later, unmodified.
      sec_step_next  = tick;
      min_step_next  = sec_carry;
      hr_step_next   = min_carry;
      blink_next     = 1'b0;
      blink_cnt_next = 16'd0;
      hold_cnt_next  = 16'd0;
      rep_cnt_next   = 16'd0;
      rep_phase_next = 1'b0;
    end else if (mode_change) begin
      // Mode change wins over a simultaneous key_inc; everything restarts.
      blink_next     = 1'b0;
      blink_cnt_next = 16'd0;
      hold_cnt_next  = 16'd0;
      rep_cnt_next   = 16'd0;
      rep_phase_next = 1'b0;
    end else begin
      step_req = inc_rise;
      if (mode_reg == MODE_SET_HR || mode_reg == MODE_SET_MIN) begin
        if (!key_inc) begin
          hold_cnt_next  = 16'd0;
          rep_cnt_next   = 16'd0;
          rep_phase_next = 1'b0;
        end else if (!rep_phase_reg) begin
          if (hold_cnt_reg == HOLD_CYCLES - 16'd1) begin
            step_req       = 1'b1;
            rep_phase_next = 1'b1;
            rep_cnt_next   = 16'd0;
          end else begin
            hold_cnt_next = hold_cnt_reg + 16'd1;
          end
        end else if (rep_cnt_reg == REPEAT_CYCLES - 16'd1) begin
          step_req     = 1'b1;
          rep_cnt_next = 16'd0;
        end else begin
          rep_cnt_next = rep_cnt_reg + 16'd1;
        end
      end

      case (mode_reg)
        MODE_SET_HR:  hr_step_next  = step_req;
        MODE_SET_MIN: min_step_next = step_req;
        default:      sec_clr_next  = step_req;
      endcase

      // A change restarts the half-period with the field shown.
      if (step_req) begin
        blink_next     = 1'b0;
        blink_cnt_next = 16'd0;
      end else if (blink_cnt_reg == BLINK_DIV - 16'd1) begin
        blink_next     = ~blink_reg;
        blink_cnt_next = 16'd0;
      end else begin
        blink_cnt_next = blink_cnt_reg + 16'd1;
      end
    end
  end

  // State, key history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg      <= MODE_RUN;
      mode_q_reg    <= 1'b0;
      inc_q_reg     <= 1'b0;
      sec_step_reg  <= 1'b0;
      min_step_reg  <= 1'b0;
      hr_step_reg   <= 1'b0;
      sec_clr_reg   <= 1'b0;
      blink_reg     <= 1'b0;
      blink_cnt_reg <= 16'd0;
      hold_cnt_reg  <= 16'd0;
      rep_cnt_reg   <= 16'd0;
      rep_phase_reg <= 1'b0;
    end else begin
      mode_reg      <= mode_next;
      mode_q_reg    <= key_mode;
      inc_q_reg     <= key_inc;
      sec_step_reg  <= sec_step_next;
      min_step_reg  <= min_step_next;
      hr_step_reg   <= hr_step_next;
      sec_clr_reg   <= sec_clr_next;
      blink_reg     <= blink_next;
      blink_cnt_reg <= blink_cnt_next;
      hold_cnt_reg  <= hold_cnt_next;
      rep_cnt_reg   <= rep_cnt_next;
      rep_phase_reg <= rep_phase_next;
    end
  end

  assign sec_step = sec_step_reg;
  assign min_step = min_step_reg;
  assign hr_step  = hr_step_reg;
  assign sec_clr  = sec_clr_reg;
  assign mode     = mode_reg;
  assign blink    = blink_reg;

endmodule
